conv1_sched: RTL and testbench

Sequencer for the first convolution stage's line-buffer/window datapath. It sits between the pixel source and the five-line-buffer and 5x5 window array. It accepts one raster-scanned frame per `start` through a valid/ready handshake. It drives line-buffer write/read addresses and the window shift enable, and flags each position where the 5x5 window holds a complete valid patch, with downstream backpressure.

---
 rtl/conv1_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_conv1_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv1_sched
// Description : Sequencer for the first convolution stage. It accepts one
//               raster-scanned frame per start pulse over a valid/ready
//               handshake, drives the five-line-buffer write/read addresses
//               and window shift enable, and flags every position where the
//               KxK window holds a complete patch. Downstream backpressure
//               stalls pixel intake so the window never shifts under an
//               unconsumed output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous reset, ACTIVE-HIGH despite the name
//   start       in   begin a frame (sampled only while idle)
//   in_valid    in   upstream pixel present
//   in_ready    out  pixel accepted this cycle when in_valid is also high
//   out_ready   in   downstream consumes the current window
//   lb_wr_en    out  line-buffer write enable / window shift enable
//   lb_wr_addr  out  line-buffer write address (current column)
//   lb_rd_addr  out  line-buffer read address (one column ahead of write)
//   win_valid   out  window holds a complete KxK patch
//   win_row     out  output row of the current window
//   win_col     out  output column of the current window
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse after the final window is consumed
// Optional (macro CNN_CONV1_FRAME_CNT_EN)
//   cnt_clr     in   synchronous clear of frame_cnt (wins over increment)
//   frame_cnt   out  16-bit wrapping count of completed frames
// ============================================================================
module conv1_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              lb_wr_en,
    output logic [ADDR_W-1:0] lb_wr_addr,
    output logic [ADDR_W-1:0] lb_rd_addr,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_row,
    output logic [ADDR_W-1:0] win_col,
    output logic              busy,
    output logic              frame_done
`ifdef CNN_CONV1_FRAME_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       frame_cnt
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] c_ROW_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_KM1      = ADDR_W'(K - 1);
    localparam logic [ADDR_W:0]   c_ONE_EXT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   c_W_EXT    = (ADDR_W + 1)'(IMG_W);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_win_valid;
    logic [ADDR_W-1:0] r_win_row;
    logic [ADDR_W-1:0] r_win_col;
    logic              r_frame_done;

    logic              w_in_ready;
    logic              w_busy;
    logic              w_start_frame;
    logic              w_flush_done;
    logic              w_accept;
    logic              w_col_last;
    logic              w_last_pix;
    logic              w_win_hit;
    logic [ADDR_W-1:0] w_col_nxt;
    logic [ADDR_W:0]   w_rd_sum;
    logic [ADDR_W:0]   w_rd_wrap;
    logic [ADDR_W-1:0] w_rd_nxt;

    // ------------------------------------------------------------------
    // Datapath combinational helpers
    // ------------------------------------------------------------------
    assign w_accept   = in_valid && w_in_ready;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_last_pix = w_col_last && (r_row == c_ROW_LAST);
    assign w_col_nxt  = w_col_last ? '0 : (r_col + c_ONE);

    // Read address runs one column ahead of the write address to cover the
    // one-cycle RAM read latency. IMG_W need not be a power of two, so the
    // wrap is a compare-and-subtract.
    assign w_rd_sum  = {1'b0, w_col_nxt} + c_ONE_EXT;
    assign w_rd_wrap = w_rd_sum - c_W_EXT;
    assign w_rd_nxt  = (w_rd_sum >= c_W_EXT) ? w_rd_wrap[ADDR_W-1:0]
                                             : w_rd_sum[ADDR_W-1:0];

    // The pixel being accepted completes a KxK patch once both its row and
    // column have reached K-1; this also guards the coordinate subtraction.
    assign w_win_hit = w_accept && (r_row >= c_KM1) && (r_col >= c_KM1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (start)                   w_state_nxt = c_ST_STREAM;
            c_ST_STREAM: if (w_accept && w_last_pix)  w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH:  if (w_flush_done)            w_state_nxt = c_ST_IDLE;
            default:                                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready    = 1'b0;
        w_busy        = 1'b1;
        w_start_frame = 1'b0;
        w_flush_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy        = 1'b0;
                w_start_frame = start;
            end
            c_ST_STREAM: begin
                // An unconsumed window freezes intake in the same cycle.
                w_in_ready = !(r_win_valid && !out_ready);
            end
            c_ST_FLUSH: begin
                w_flush_done = !r_win_valid || out_ready;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Raster position and read address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_rd_addr <= '0;
        end else if (w_start_frame) begin
            r_col     <= '0;
            r_row     <= '0;
            r_rd_addr <= '0;
        end else if (w_accept) begin
            r_col     <= w_col_nxt;
            r_rd_addr <= w_rd_nxt;
            if (w_last_pix) begin
                r_row <= '0;
            end else if (w_col_last) begin
                r_row <= r_row + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window valid / coordinates and frame completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // A new patch in the same cycle as a consume reloads rather
            // than clears, so back-to-back windows stay valid.
            if (w_win_hit) begin
                r_win_valid <= 1'b1;
                r_win_row   <= r_row - c_KM1;
                r_win_col   <= r_col - c_KM1;
            end else if (out_ready) begin
                r_win_valid <= 1'b0;
            end
            r_frame_done <= w_flush_done;
        end
    end

`ifdef CNN_CONV1_FRAME_CNT_EN
    // ------------------------------------------------------------------
    // Completed-frame counter
    // ------------------------------------------------------------------
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_frame_cnt <= '0;
        end else if (cnt_clr) begin
            r_frame_cnt <= '0;
        end else if (r_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign lb_wr_en   = w_accept;
    assign lb_wr_addr = r_col;
    assign lb_rd_addr = r_rd_addr;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign busy       = w_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv1_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1_sched
// Description : Self-checking bench for conv1_sched. A frame-level reference
//               model (pixel counter, pending-window flag, phase) predicts all
//               outputs each cycle; consumed windows are compared against a
//               raster-order golden list. Optional frame counter is exercised
//               when CNN_CONV1_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_sched;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int KK = 5;
    localparam int NW = (H - KK + 1) * (W - KK + 1);

    localparam int PH_IDLE   = 0;
    localparam int PH_STREAM = 1;
    localparam int PH_FLUSH  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, out_ready;
    logic       in_ready, lb_wr_en, win_valid, busy, frame_done;
    logic [4:0] lb_wr_addr, lb_rd_addr, win_row, win_col;
`ifdef CNN_CONV1_FRAME_CNT_EN
    logic        cnt_clr;
    logic [15:0] frame_cnt;
`endif

    conv1_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .lb_wr_en   (lb_wr_en),
        .lb_wr_addr (lb_wr_addr),
        .lb_rd_addr (lb_rd_addr),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CNN_CONV1_FRAME_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_ph  = PH_IDLE;
    int m_n   = 0;       // pixels accepted in the current frame
    bit m_wv  = 0;       // a window is outstanding
    int m_wr  = 0;
    int m_wc  = 0;
    bit m_fd  = 0;
    int m_cnt = 0;
    bit force_clr  = 0;
    bit clr_on_fd  = 0;

    // Values observed in the last cycle
    logic       s_rdy, s_acc, s_wv, s_fd;
    logic [4:0] s_wr, s_row, s_col;

    typedef struct packed { logic [4:0] r; logic [4:0] c; } coord_t;
    coord_t consumed[$];

    typedef struct { logic [4:0] wr; logic [4:0] rd; } addr_vec_t;
    addr_vec_t tbl[30];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_n = 0; m_wv = 0; m_wr = 0; m_wc = 0; m_fd = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    // Entered and left at posedge+1.
    task automatic cyc(input logic st, input logic iv, input logic ordy);
        logic       exp_rdy, acc, clr;
        logic [4:0] e_wr, e_rd;
        int         r, c, fd_n;
        start = st; in_valid = iv; out_ready = ordy;
        clr = force_clr || (clr_on_fd && m_fd);
`ifdef CNN_CONV1_FRAME_CNT_EN
        cnt_clr = clr;
`endif
        #1;
        exp_rdy = (m_ph == PH_STREAM) && !(m_wv && !ordy);
        acc     = iv && exp_rdy;
        e_wr    = 5'(m_n % W);
        e_rd    = (m_n == 0) ? 5'd0 : 5'(((m_n % W) + 1) % W);
        chk("cycle_ctrl",
            {17'd0, in_ready, lb_wr_en, busy, win_valid, frame_done, lb_wr_addr, lb_rd_addr},
            {17'd0, exp_rdy, acc, (m_ph != PH_IDLE), m_wv, m_fd, e_wr, e_rd});
        if (m_wv) chk("cycle_coord", {22'd0, win_row, win_col}, {22'd0, 5'(m_wr), 5'(m_wc)});
`ifdef CNN_CONV1_FRAME_CNT_EN
        chk("cycle_cnt", {16'd0, frame_cnt}, 32'(m_cnt & 16'hffff));
`endif
        s_rdy = in_ready; s_acc = lb_wr_en; s_wv = win_valid; s_fd = frame_done;
        s_wr = lb_wr_addr; s_row = win_row; s_col = win_col;
        if (win_valid && ordy) consumed.push_back({win_row, win_col});

        // Model advance
        fd_n = 0;
        if (m_wv && ordy) m_wv = 0;
        case (m_ph)
            PH_IDLE: if (st) begin m_ph = PH_STREAM; m_n = 0; end
            PH_STREAM: if (acc) begin
                r = m_n / W; c = m_n % W; m_n++;
                if (r >= KK - 1 && c >= KK - 1) begin
                    m_wv = 1; m_wr = r - (KK - 1); m_wc = c - (KK - 1);
                end
                if (m_n == W * H) m_ph = PH_FLUSH;
            end
            default: if (!m_wv) begin m_ph = PH_IDLE; fd_n = 1; end
        endcase
        if (clr) m_cnt = 0;
        else if (m_fd) m_cnt = (m_cnt + 1) & 16'hffff;
        m_fd = (fd_n != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int piv, input int por, input int bound);
        int n = 0;
        while ((m_ph != PH_IDLE || m_fd) && n < bound) begin
            cyc(1'b0, pct(piv), pct(por));
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #2;
        model_reset();
        chk("reset_outs",
            {6'd0, in_ready, lb_wr_en, busy, win_valid, frame_done, lb_wr_addr, lb_rd_addr, win_row, win_col},
            32'd0);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int first_k, wv_cnt, fd_cnt, fd_k, acc_cnt, n;
        logic [4:0] fr, fc, lr, lc;

        // Address table for the first 30 accepts
        for (int i = 0; i < 30; i++) begin
            tbl[i].wr = (i < W) ? 5'(i) : 5'(i - W);
            tbl[i].rd = (i + 2 < W) ? 5'(i + 2) : 5'(i + 2 - W);
        end

        start = 0; in_valid = 0; out_ready = 0;
`ifdef CNN_CONV1_FRAME_CNT_EN
        cnt_clr = 0;
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);

        // ---------------- Full-rate frame ----------------
        cyc(1'b1, 1'b0, 1'b1);
        first_k = -1; wv_cnt = 0; fd_cnt = 0; fd_k = -1;
        fr = '1; fc = '1; lr = '0; lc = '0;
        for (int k = 0; k < 790; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (k < 30) begin
                chk("wr_addr_seq", {27'd0, s_wr}, {27'd0, tbl[k].wr});
                chk("rd_addr_seq", {27'd0, lb_rd_addr}, {27'd0, tbl[k].rd});
            end
            if (s_wv) begin
                wv_cnt++;
                if (first_k < 0) begin first_k = k; fr = s_row; fc = s_col; end
                lr = s_row; lc = s_col;
            end
            if (s_fd) begin fd_cnt++; fd_k = k; end
        end
        chk("win_count", 32'(wv_cnt), 32'(NW));
        chk("first_win_cycle", 32'(first_k), 32'd117);
        chk("first_win_coord", {22'd0, fr, fc}, 32'd0);
        chk("last_win_coord", {22'd0, lr, lc}, {22'd0, 5'd23, 5'd23});
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_done_cycle", 32'(fd_k), 32'd785);

        // ---------------- Backpressure at window (3,7) ----------------
        cyc(1'b1, 1'b0, 1'b1);
        n = 0;
        while (!(m_wv && m_wr == 3 && m_wc == 7) && n < 400) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("reach_win_3_7", 32'(n < 400), 32'd1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("stall_ready", {30'd0, s_rdy, s_acc}, 32'd0);
            chk("stall_coord", {22'd0, s_row, s_col}, {22'd0, 5'd3, 5'd7});
        end
        cyc(1'b0, 1'b1, 1'b1);
        chk("after_release", {21'd0, win_valid, win_row, win_col}, {21'd0, 1'b1, 5'd3, 5'd8});
        run_until_idle(100, 100, 2000);

        // ---------------- Random gaps and backpressure ----------------
        consumed.delete();
        cyc(1'b1, 1'b0, 1'b0);
        run_until_idle(70, 60, 6000);
        chk("golden_len", 32'(consumed.size()), 32'(NW));
        n = 0;
        for (int r = 0; r <= H - KK; r++) begin
            for (int c = 0; c <= W - KK; c++) begin
                if (n < consumed.size())
                    chk("golden_win", {22'd0, consumed[n]}, {22'd0, 5'(r), 5'(c)});
                n++;
            end
        end

        // ---------------- Reset mid-frame ----------------
        cyc(1'b1, 1'b0, 1'b1);
        n = 0;
        while (m_n < 400 && n < 1000) begin
            cyc(1'b0, pct(80), 1'b1);
            n++;
        end
        chk("reach_accept_400", 32'(m_n), 32'd400);
        do_reset();
        fd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (s_fd) fd_cnt++;
        end
        chk("no_done_after_reset", 32'(fd_cnt), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        acc_cnt = 0; n = 0;
        s_wv = 0;
        while (n < 300) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
            if (s_wv) break;
            if (s_acc) acc_cnt++;
        end
        chk("restart_first_win", {21'd0, s_wv, s_row, s_col}, {21'd0, 1'b1, 5'd0, 5'd0});
        chk("restart_accepts", 32'(acc_cnt), 32'd117);
        run_until_idle(100, 100, 2000);

`ifdef CNN_CONV1_FRAME_CNT_EN
        // ---------------- Frame counter ----------------
        begin
            int exp_cnt[3];
            exp_cnt[0] = 1; exp_cnt[1] = 0; exp_cnt[2] = 1;
            force_clr = 1;
            cyc(1'b0, 1'b0, 1'b1);
            force_clr = 0;
            for (int f = 0; f < 3; f++) begin
                clr_on_fd = (f == 1);
                cyc(1'b1, 1'b0, 1'b1);
                run_until_idle(100, 100, 2000);
                clr_on_fd = 0;
                chk("frame_cnt", {16'd0, frame_cnt}, 32'(exp_cnt[f]));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
